// File: rtl/vt52_kbd_pkg.sv
// Set-2 scancode constants, decoder state, pending-sequence record and the
// scancode-to-ASCII table shared by the VT52 keyboard path.
package vt52_kbd_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] ASCII_ESC = 8'h1B;
    localparam logic [2:0] PAUSE_TAIL_LAST = 3'd6;

    typedef enum logic [1:0] {IDLE, PAUSE_SKIP, EMIT1, EMIT2} kbd_state_e;

    typedef struct packed {
        logic       two;
        logic [7:0] b0;
        logic [7:0] b1;
    } kbd_seq_t;

    function automatic logic [7:0] kbd_lookup(input logic [7:0] code, input logic shift);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = 8'h00;
        hi = 8'h00;
        case (code)
            8'h1C: lo = "a";  8'h32: lo = "b";  8'h21: lo = "c";  8'h23: lo = "d";
            8'h24: lo = "e";  8'h2B: lo = "f";  8'h34: lo = "g";  8'h33: lo = "h";
            8'h43: lo = "i";  8'h3B: lo = "j";  8'h42: lo = "k";  8'h4B: lo = "l";
            8'h3A: lo = "m";  8'h31: lo = "n";  8'h44: lo = "o";  8'h4D: lo = "p";
            8'h15: lo = "q";  8'h2D: lo = "r";  8'h1B: lo = "s";  8'h2C: lo = "t";
            8'h3C: lo = "u";  8'h2A: lo = "v";  8'h1D: lo = "w";  8'h22: lo = "x";
            8'h35: lo = "y";  8'h1A: lo = "z";
            8'h16: {lo, hi} = "1!";  8'h1E: {lo, hi} = "2@";  8'h26: {lo, hi} = "3#";
            8'h25: {lo, hi} = "4$";  8'h2E: {lo, hi} = "5%";  8'h36: {lo, hi} = "6^";
            8'h3D: {lo, hi} = "7&";  8'h3E: {lo, hi} = "8*";  8'h46: {lo, hi} = "9(";
            8'h45: {lo, hi} = "0)";  8'h0E: {lo, hi} = "`~";  8'h4E: {lo, hi} = "-_";
            8'h55: {lo, hi} = "=+";  8'h54: {lo, hi} = "[{";  8'h5B: {lo, hi} = "]}";
            8'h5D: {lo, hi} = "\\|"; 8'h4C: {lo, hi} = ";:";  8'h52: {lo, hi} = "'\"";
            8'h41: {lo, hi} = ",<";  8'h49: {lo, hi} = ".>";  8'h4A: {lo, hi} = "/?";
            8'h5A: {lo, hi} = 16'h0D0D;
            8'h66: {lo, hi} = 16'h0808;
            8'h0D: {lo, hi} = 16'h0909;
            8'h76: {lo, hi} = 16'h1B1B;
            8'h29: {lo, hi} = 16'h2020;
            default: {lo, hi} = 16'h0000;
        endcase
        // letters only carry the lowercase entry; uppercase is a fixed offset
        if (lo >= "a" && lo <= "z") begin
            hi = lo - 8'h20;
        end
        return shift ? hi : lo;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronises the pins, samples data on clock falls, checks framing.
// Latency: code_valid one clk after the stop-bit fall is seen; no backpressure, codes are pulses.
module ps2_rx #(
    parameter int SYNC_STAGES  = 2,
    parameter int TIMEOUT_BITS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_error
);

    logic [SYNC_STAGES-1:0]  clk_sync_q;
    logic [SYNC_STAGES-1:0]  dat_sync_q;
    logic                    clk_prev_q;
    logic [3:0]              bit_cnt_q;
    logic [7:0]              shift_q;
    logic                    par_q;
    logic [TIMEOUT_BITS-1:0] tmo_q;
    logic [7:0]              code_q;
    logic                    code_vld_q;
    logic                    ferr_q;
    logic                    clk_s;
    logic                    dat_s;
    logic                    fall;

    assign clk_s = clk_sync_q[SYNC_STAGES-1];
    assign dat_s = dat_sync_q[SYNC_STAGES-1];
    assign fall  = clk_prev_q & ~clk_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'h00;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            code_q     <= 8'h00;
            code_vld_q <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
            clk_prev_q <= clk_s;
            code_vld_q <= 1'b0;
            ferr_q     <= 1'b0;
            if (fall) begin
                tmo_q <= '0;
                if (bit_cnt_q == 4'd0) begin
                    if (!dat_s) bit_cnt_q <= 4'd1;
                    else        ferr_q    <= 1'b1;
                end else if (bit_cnt_q <= 4'd8) begin
                    shift_q   <= {dat_s, shift_q[7:1]};
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end else if (bit_cnt_q == 4'd9) begin
                    par_q     <= dat_s;
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end else begin
                    // parity is judged at the stop bit so a bad frame ends cleanly
                    bit_cnt_q <= 4'd0;
                    if (dat_s && (^{shift_q, par_q})) begin
                        code_q     <= shift_q;
                        code_vld_q <= 1'b1;
                    end else begin
                        ferr_q <= 1'b1;
                    end
                end
            end else if (bit_cnt_q != 4'd0) begin
                if (&tmo_q) begin
                    bit_cnt_q <= 4'd0;
                    tmo_q     <= '0;
                    ferr_q    <= 1'b1;
                end else begin
                    tmo_q <= tmo_q + TIMEOUT_BITS'(1);
                end
            end
        end
    end

    assign code        = code_q;
    assign code_valid  = code_vld_q;
    assign frame_error = ferr_q;

endmodule

// File: rtl/ps2_keyboard_encoder.sv
// PS/2 set-2 keyboard to VT52 host byte stream with modifier tracking and cursor escapes.
// Latency: valid 2 clk after a decoded code; data held while valid && !ready, busy keys dropped.
module ps2_keyboard_encoder
    import vt52_kbd_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int TIMEOUT_BITS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       caps_lock,
    output logic       frame_error,
    output logic       overflow
);

    logic [7:0] code;
    logic       code_valid;

    ps2_rx #(.SYNC_STAGES(SYNC_STAGES), .TIMEOUT_BITS(TIMEOUT_BITS)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .code       (code),
        .code_valid (code_valid),
        .frame_error(frame_error)
    );

    kbd_state_e state_q;
    kbd_seq_t   seq_q;
    kbd_seq_t   key_seq;
    logic       shift_q, ctrl_q, caps_q, ext_q, brk_q;
    logic       shift_d, ctrl_d, caps_d, ext_d, brk_d;
    logic       pend_q, valid_q, ovf_q;
    logic [7:0] data_q;
    logic [2:0] skip_q;
    logic       busy, key_hit, go_pause, is_letter;
    logic [7:0] lc, arrow;

    // the registered lookup stage counts as busy so nothing can overtake it
    assign busy = pend_q || (state_q == EMIT1) || (state_q == EMIT2);

    always_comb begin
        shift_d  = shift_q;
        ctrl_d   = ctrl_q;
        caps_d   = caps_q;
        ext_d    = ext_q;
        brk_d    = brk_q;
        key_seq  = '0;
        key_hit  = 1'b0;
        go_pause = 1'b0;
        lc        = kbd_lookup(code, 1'b0);
        is_letter = (lc >= "a") && (lc <= "z");
        case (code)
            8'h75:   arrow = "A";
            8'h72:   arrow = "B";
            8'h74:   arrow = "C";
            8'h6B:   arrow = "D";
            default: arrow = 8'h00;
        endcase
        if (code_valid && state_q != PAUSE_SKIP) begin
            if (code == SC_EXT) begin
                ext_d = 1'b1;
            end else if (code == SC_BRK) begin
                brk_d = 1'b1;
            end else if (code == SC_PAUSE) begin
                go_pause = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (code == SC_LSHIFT || code == SC_RSHIFT) begin
                    shift_d = !brk_q;
                end else if (code == SC_CTRL) begin
                    ctrl_d = !brk_q;
                end else if (!brk_q) begin
                    if (code == SC_CAPS) begin
                        caps_d = !caps_q;
                    end else if (ext_q && arrow != 8'h00) begin
                        key_seq.two = 1'b1;
                        key_seq.b0  = ASCII_ESC;
                        key_seq.b1  = arrow;
                    end else if (ctrl_q && is_letter) begin
                        key_seq.b0 = lc & 8'h1F;
                    end else if (is_letter) begin
                        key_seq.b0 = kbd_lookup(code, caps_q ^ shift_q);
                    end else begin
                        key_seq.b0 = kbd_lookup(code, shift_q);
                    end
                    key_hit = (key_seq.b0 != 8'h00);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            seq_q   <= '0;
            shift_q <= 1'b0;
            ctrl_q  <= 1'b0;
            caps_q  <= 1'b0;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            data_q  <= 8'h00;
            skip_q  <= 3'd0;
        end else begin
            shift_q <= shift_d;
            ctrl_q  <= ctrl_d;
            caps_q  <= caps_d;
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            ovf_q   <= key_hit && busy;
            pend_q  <= key_hit && !busy;
            if (key_hit && !busy) seq_q <= key_seq;
            case (state_q)
                IDLE: begin
                    if (pend_q) begin
                        data_q  <= seq_q.b0;
                        valid_q <= 1'b1;
                        state_q <= EMIT1;
                    end else if (go_pause) begin
                        skip_q  <= 3'd0;
                        state_q <= PAUSE_SKIP;
                    end
                end
                PAUSE_SKIP: begin
                    if (code_valid) begin
                        skip_q <= skip_q + 3'd1;
                        if (skip_q == PAUSE_TAIL_LAST) state_q <= IDLE;
                    end
                end
                EMIT1: begin
                    if (ready) begin
                        if (seq_q.two) begin
                            data_q  <= seq_q.b1;
                            state_q <= EMIT2;
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                EMIT2: begin
                    if (ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign caps_lock = caps_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_keyboard_encoder.sv
// Directed bench for ps2_keyboard_encoder: bit-banged PS/2 frames, byte capture, pulse counting.
module tb_ps2_keyboard_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       caps_lock;
    logic       frame_error;
    logic       overflow;

    int         checks   = 0;
    int         failures = 0;
    int         ovf_cnt  = 0;
    int         ferr_cnt = 0;
    logic [7:0] rx_q[$];

    always #5 clk = ~clk;

    ps2_keyboard_encoder dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .caps_lock  (caps_lock),
        .frame_error(frame_error),
        .overflow   (overflow)
    );

    always @(negedge clk) begin
        if (!reset) begin
            if (valid && ready) rx_q.push_back(data);
            if (overflow)       ovf_cnt++;
            if (frame_error)    ferr_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            tick(5);
            ps2_clk = 1'b0;
            tick(5);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 11);
        tick(20);
    endtask

    task automatic check_rx(input string tag, input int n, input logic [23:0] exp);
        logic [7:0] got;
        check({tag, "_count"}, rx_q.size(), n);
        for (int i = 0; i < n; i++) begin
            got = 8'hxx;
            if (i < rx_q.size()) got = rx_q[i];
            check(tag, {24'h0, got}, {24'h0, exp[23-8*i -: 8]});
        end
        rx_q.delete();
    endtask

    task automatic wait_valid(input string tag);
        int w;
        w = 0;
        while (valid !== 1'b1 && w < 300) begin
            tick(1);
            w++;
        end
        check(tag, valid, 1);
    endtask

    initial begin
        int w;
        int bad;
        int f0;
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        ready    = 1'b1;
        tick(4);
        check("rst_data", data, 0);
        check("rst_valid", valid, 0);
        check("rst_caps", caps_lock, 0);
        check("rst_ferr", frame_error, 0);
        check("rst_ovf", overflow, 0);
        reset = 1'b0;
        tick(5);

        // plain key, then its break code
        send(8'h1C); send(8'hF0); send(8'h1C);
        tick(10);
        check_rx("t1", 1, 24'h610000);

        // shift held across one key
        send(8'h12); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C);
        tick(10);
        check_rx("t2", 2, 24'h416100);

        // caps lock, then caps with shift
        send(8'h58); send(8'hF0); send(8'h58); send(8'h1C);
        tick(10);
        check_rx("t3_caps", 1, 24'h410000);
        check("t3_caps_on", caps_lock, 1);
        send(8'h12); send(8'h1C);
        tick(10);
        check_rx("t3_caps_shift", 1, 24'h610000);
        send(8'hF0); send(8'h12); send(8'h58); send(8'hF0); send(8'h58);
        check("t3_caps_off", caps_lock, 0);

        // cursor up with the sink stalled
        ready = 1'b0;
        send(8'hE0); send(8'h75);
        wait_valid("t4_valid");
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!(valid === 1'b1 && data === 8'h1B)) bad++;
            tick(1);
        end
        check("t4_stall_bad_cycles", bad, 0);
        ready = 1'b1;
        tick(4);
        check_rx("t4_up", 2, 24'h1B4100);
        send(8'hE0); send(8'hF0); send(8'h75);
        tick(10);
        check_rx("t4_brk", 0, 24'h0);
        check("t4_no_ovf", ovf_cnt, 0);

        // key arriving while a sequence is stalled is dropped
        ready = 1'b0;
        send(8'hE0); send(8'h6B); send(8'h1C);
        check("t5_ovf", ovf_cnt, 1);
        ready = 1'b1;
        tick(5);
        check_rx("t5_left", 2, 24'h1B4400);
        send(8'h14); send(8'h21);
        tick(10);
        check_rx("t5_ctrl_c", 1, 24'h030000);
        send(8'hF0); send(8'h14);
        check("t5_ovf_total", ovf_cnt, 1);

        // bad parity
        send_frame(8'h1C, 1'b1, 11);
        tick(20);
        check("t6_par_ferr", ferr_cnt, 1);
        check_rx("t6_par", 0, 24'h0);

        // frame cut after start + 4 data bits
        send_frame(8'h1C, 1'b0, 5);
        f0 = ferr_cnt;
        w  = 0;
        while (ferr_cnt == f0 && w < 70000) begin
            tick(1);
            w++;
        end
        check("t6_tmo_ferr", ferr_cnt, 2);
        check("t6_tmo_latency_in_window", (w >= 65500 && w <= 65560), 1);
        send(8'h29);
        tick(10);
        check_rx("t6_space", 1, 24'h200000);

        // reset while the second byte of an escape is pending
        ready = 1'b0;
        send(8'hE0); send(8'h75);
        wait_valid("t6_esc_valid");
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        tick(1);
        check("t6_emit2", {23'h0, valid, data}, {23'h0, 1'b1, 8'h41});
        reset = 1'b1;
        tick(1);
        check("t6_rst_valid", valid, 0);
        check("t6_rst_data", data, 0);
        reset = 1'b0;
        ready = 1'b1;
        tick(3);
        check("t6_post_valid", valid, 0);
        rx_q.delete();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
